// File: rtl/ctrl_pipe_chain.sv
// Control-word pipeline Decode -> E -> M -> W ... with valid bits, bubbles, E flush and multi-cycle E hold.
// Optional stall-cycle counter enabled by CTRL_PIPE_STALL_CNT_EN (ties stall_cycles to 0 when undefined).
module ctrl_pipe_chain #(
  parameter int W      = 8,
  parameter int STAGES = 3,
  parameter int MCYC   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [W-1:0]          ctrlD,
  input  logic                  validD,
  input  logic                  mcD,
  input  logic                  stallD,
  input  logic                  flushE,
  output logic [STAGES*W-1:0]   ctrl_q,
  output logic [STAGES-1:0]     valid_q,
  output logic                  busyE,
  output logic                  stall_req,
  output logic [15:0]           stall_cycles
);

  localparam int CNTW = (MCYC > 1) ? $clog2(MCYC) : 1;
  localparam logic [CNTW-1:0] LOADVAL = CNTW'(MCYC - 1);
  localparam bit MCEN = (MCYC > 1);

  logic [W-1:0]      ctrlR [STAGES];
  logic [STAGES-1:0] validR;
  logic [CNTW-1:0]   cnt;

  assign busyE     = (cnt != '0);
  assign stall_req = busyE & ~flushE;

  always_comb begin
    ctrl_q = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      ctrl_q[k*W +: W] = ctrlR[k];
    end
  end
  assign valid_q = validR;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        ctrlR[k] <= '0;
      end
      validR <= '0;
      cnt    <= '0;
    end else begin
      for (int unsigned k = 2; k < STAGES; k++) begin
        ctrlR[k]  <= ctrlR[k-1];
        validR[k] <= validR[k-1];
      end
      // A held (or flushed-while-held) word must not leak into stage 1.
      if (busyE) begin
        ctrlR[1]  <= '0;
        validR[1] <= 1'b0;
      end else begin
        ctrlR[1]  <= ctrlR[0];
        validR[1] <= validR[0];
      end

      if (flushE) begin
        ctrlR[0]  <= '0;
        validR[0] <= 1'b0;
        cnt       <= '0;
      end else if (busyE) begin
        cnt <= cnt - 1'b1;
      end else if (stallD) begin
        ctrlR[0]  <= '0;
        validR[0] <= 1'b0;
      end else begin
        ctrlR[0]  <= ctrlD;
        validR[0] <= validD;
        cnt       <= (MCEN && validD && mcD) ? LOADVAL : '0;
      end
    end
  end

`ifdef CTRL_PIPE_STALL_CNT_EN
  logic [15:0] stallCnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stallCnt <= '0;
    end else if ((stall_req || stallD) && (stallCnt != '1)) begin
      stallCnt <= stallCnt + 16'd1;
    end
  end

  assign stall_cycles = stallCnt;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_ctrl_pipe_chain.sv
// Self-checking bench for ctrl_pipe_chain: directed scenarios plus randomized run against a behavioural model.
module tb_ctrl_pipe_chain;

  localparam int W      = 8;
  localparam int STAGES = 3;
  localparam int MCYC   = 4;

  logic                clk = 1'b0;
  logic                reset;
  logic [W-1:0]        ctrlD;
  logic                validD, mcD, stallD, flushE;
  logic [STAGES*W-1:0] ctrl_q;
  logic [STAGES-1:0]   valid_q;
  logic                busyE, stall_req;
  logic [15:0]         stall_cycles;

  int tests = 0;
  int fails = 0;

  ctrl_pipe_chain #(.W(W), .STAGES(STAGES), .MCYC(MCYC)) dut (
    .clk(clk), .reset(reset), .ctrlD(ctrlD), .validD(validD), .mcD(mcD),
    .stallD(stallD), .flushE(flushE), .ctrl_q(ctrl_q), .valid_q(valid_q),
    .busyE(busyE), .stall_req(stall_req), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  // Behavioural model: per-stage word list plus "cycles E still owes" and stall tally.
  logic [W-1:0] mCtrl [STAGES];
  logic         mValid [STAGES];
  int           mHold;
  int           mStall;

  task automatic modelReset();
    for (int k = 0; k < STAGES; k++) begin
      mCtrl[k] = '0;
      mValid[k] = 1'b0;
    end
    mHold = 0;
    mStall = 0;
  endtask

  task automatic modelStep();
    bit held;
    held = (mHold > 0);
    if ((held && !flushE) || stallD) mStall = (mStall < 65535) ? mStall + 1 : 65535;
    for (int k = STAGES - 1; k >= 2; k--) begin
      mCtrl[k] = mCtrl[k-1];
      mValid[k] = mValid[k-1];
    end
    if (held) begin
      mCtrl[1] = '0;
      mValid[1] = 1'b0;
    end else begin
      mCtrl[1] = mCtrl[0];
      mValid[1] = mValid[0];
    end
    if (flushE) begin
      mCtrl[0] = '0; mValid[0] = 1'b0; mHold = 0;
    end else if (held) begin
      mHold = mHold - 1;
    end else if (stallD) begin
      mCtrl[0] = '0; mValid[0] = 1'b0;
    end else begin
      mCtrl[0] = ctrlD; mValid[0] = validD;
      mHold = (validD && mcD && MCYC > 1) ? MCYC - 1 : 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    ctrlD = '0; validD = 1'b0; mcD = 1'b0; stallD = 1'b0; flushE = 1'b0;
  endtask

  task automatic doReset();
    reset = 1'b1;
    idleInputs();
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    doReset();
    tests++;
    if (ctrl_q !== '0 || valid_q !== '0 || busyE !== 1'b0 || stall_req !== 1'b0 || stall_cycles !== 16'd0) begin
      $display("FAIL reset: ctrl=%h valid=%b busy=%b req=%b cnt=%0d, want all zero",
               ctrl_q, valid_q, busyE, stall_req, stall_cycles);
      fails++;
    end
  endtask

  task automatic test_single();
    ctrlD = 8'hA5; validD = 1'b1;
    step();
    idleInputs();
    tests++;
    if (valid_q !== 3'b001 || ctrl_q !== 24'h0000A5) begin
      $display("FAIL single_e: ctrl=%h valid=%b want 0000a5/001", ctrl_q, valid_q); fails++;
    end
    step();
    tests++;
    if (valid_q !== 3'b010 || ctrl_q !== 24'h00A500) begin
      $display("FAIL single_m: ctrl=%h valid=%b want 00a500/010", ctrl_q, valid_q); fails++;
    end
    step();
    tests++;
    if (valid_q !== 3'b100 || ctrl_q !== 24'hA50000) begin
      $display("FAIL single_w: ctrl=%h valid=%b want a50000/100", ctrl_q, valid_q); fails++;
    end
    step();
    tests++;
    if (valid_q !== 3'b000 || ctrl_q !== 24'h0) begin
      $display("FAIL single_drain: ctrl=%h valid=%b want 0/000", ctrl_q, valid_q); fails++;
    end
  endtask

  task automatic test_multicycle();
    ctrlD = 8'h3C; validD = 1'b1; mcD = 1'b1;
    step();
    ctrlD = 8'h11; mcD = 1'b0;
    for (int i = 0; i < MCYC - 1; i++) begin
      tests++;
      if (busyE !== 1'b1 || stall_req !== 1'b1 || ctrl_q[7:0] !== 8'h3C || valid_q[0] !== 1'b1 || valid_q[1] !== 1'b0) begin
        $display("FAIL mc_hold[%0d]: busy=%b req=%b ctrl=%h valid=%b want 1/1/..3c/x01",
                 i, busyE, stall_req, ctrl_q, valid_q); fails++;
      end
      step();
    end
    tests++;
    if (busyE !== 1'b0 || stall_req !== 1'b0 || ctrl_q[7:0] !== 8'h3C || valid_q[1] !== 1'b0) begin
      $display("FAIL mc_last: busy=%b req=%b ctrl=%h valid=%b want 0/0/..3c stage1 bubble",
               busyE, stall_req, ctrl_q, valid_q); fails++;
    end
    step();
    idleInputs();
    tests++;
    if (ctrl_q[15:0] !== 16'h3C11 || valid_q[1:0] !== 2'b11) begin
      $display("FAIL mc_release: ctrl=%h valid=%b want ..3c11/x11", ctrl_q, valid_q); fails++;
    end
    repeat (3) step();
  endtask

  task automatic test_stall();
    ctrlD = 8'hFF; validD = 1'b1; stallD = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      tests++;
      if (valid_q !== 3'b000 || ctrl_q !== 24'h0) begin
        $display("FAIL stall_bubble[%0d]: ctrl=%h valid=%b want 0/000", i, ctrl_q, valid_q); fails++;
      end
    end
    stallD = 1'b0;
    step();
    idleInputs();
    tests++;
    if (valid_q !== 3'b001 || ctrl_q !== 24'h0000FF) begin
      $display("FAIL stall_resume: ctrl=%h valid=%b want 0000ff/001", ctrl_q, valid_q); fails++;
    end
    repeat (3) step();
  endtask

  task automatic test_flush();
    ctrlD = 8'h5A; validD = 1'b1; mcD = 1'b1;
    step();
    idleInputs();
    step();
    flushE = 1'b1;
    #1;
    tests++;
    if (stall_req !== 1'b0) begin
      $display("FAIL flush_req: stall_req=%b want 0", stall_req); fails++;
    end
    step();
    flushE = 1'b0;
    tests++;
    if (busyE !== 1'b0 || valid_q[0] !== 1'b0 || ctrl_q[7:0] !== 8'h00) begin
      $display("FAIL flush_e: busy=%b ctrl=%h valid=%b want 0/..00/xx0", busyE, ctrl_q, valid_q); fails++;
    end
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (valid_q !== 3'b000 || ctrl_q !== 24'h0) begin
        $display("FAIL flush_leak[%0d]: ctrl=%h valid=%b want 0/000", i, ctrl_q, valid_q); fails++;
      end
      step();
    end
  endtask

  task automatic test_async_reset();
    ctrlD = 8'h42; validD = 1'b1; mcD = 1'b1;
    step();
    idleInputs();
    step();
    #2;
    reset = 1'b1;
    #1;
    tests++;
    if (ctrl_q !== '0 || valid_q !== '0 || busyE !== 1'b0 || stall_req !== 1'b0 || stall_cycles !== 16'd0) begin
      $display("FAIL async_reset: ctrl=%h valid=%b busy=%b req=%b cnt=%0d want all zero",
               ctrl_q, valid_q, busyE, stall_req, stall_cycles); fails++;
    end
    #1;
    reset = 1'b0;
    ctrlD = 8'h77; validD = 1'b1;
    step();
    idleInputs();
    tests++;
    if (valid_q !== 3'b001 || ctrl_q !== 24'h000077 || busyE !== 1'b0) begin
      $display("FAIL reset_resume: ctrl=%h valid=%b busy=%b want 000077/001/0", ctrl_q, valid_q, busyE); fails++;
    end
    repeat (3) step();
  endtask

  task automatic test_stall_cnt();
    doReset();
    ctrlD = 8'h3C; validD = 1'b1; mcD = 1'b1;
    step();
    ctrlD = 8'h11; mcD = 1'b0;
    repeat (MCYC) step();
    idleInputs();
    ctrlD = 8'hFF; validD = 1'b1; stallD = 1'b1;
    repeat (2) step();
    idleInputs();
    step();
    tests++;
`ifdef CTRL_PIPE_STALL_CNT_EN
    if (stall_cycles !== 16'd5) begin
      $display("FAIL stall_cnt: got %0d want 5", stall_cycles); fails++;
    end
    stallD = 1'b1;
    repeat (65540) step();
    stallD = 1'b0;
    tests++;
    if (stall_cycles !== 16'hFFFF) begin
      $display("FAIL stall_cnt_sat: got %h want ffff", stall_cycles); fails++;
    end
`else
    if (stall_cycles !== 16'd0) begin
      $display("FAIL stall_cnt_off: got %0d want 0", stall_cycles); fails++;
    end
`endif
  endtask

  task automatic test_random();
    logic [STAGES*W-1:0] expCtrl;
    logic [STAGES-1:0]   expValid;
    int                  expCnt;
    doReset();
    modelReset();
    for (int n = 0; n < 400; n++) begin
      ctrlD  = W'($urandom);
      validD = ($urandom_range(3) != 0);
      mcD    = ($urandom_range(2) == 0);
      stallD = ($urandom_range(4) == 0);
      flushE = (mHold > 0) && ($urandom_range(5) == 0);
      #1;
      tests++;
      if (busyE !== (mHold > 0) || stall_req !== ((mHold > 0) && !flushE)) begin
        $display("FAIL rand_comb[%0d]: busy=%b req=%b want %b/%b", n, busyE, stall_req,
                 (mHold > 0), ((mHold > 0) && !flushE)); fails++;
      end
      modelStep();
      step();
      for (int k = 0; k < STAGES; k++) begin
        expCtrl[k*W +: W] = mCtrl[k];
        expValid[k] = mValid[k];
      end
`ifdef CTRL_PIPE_STALL_CNT_EN
      expCnt = mStall;
`else
      expCnt = 0;
`endif
      tests++;
      if (ctrl_q !== expCtrl || valid_q !== expValid || stall_cycles !== 16'(expCnt)) begin
        $display("FAIL rand_seq[%0d]: ctrl=%h valid=%b cnt=%0d want %h/%b/%0d", n,
                 ctrl_q, valid_q, stall_cycles, expCtrl, expValid, expCnt); fails++;
      end
    end
    idleInputs();
  endtask

  initial begin
    reset = 1'b0;
    idleInputs();
    test_reset();
    test_single();
    test_multicycle();
    test_stall();
    test_flush();
    test_async_reset();
    test_random();
    test_stall_cnt();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe_chain.md
Name: ctrl_pipe_chain

Overview:
Parametrised control-word pipeline carrying decoded control bits from Decode through STAGES register stages (E, M, W, ...).
- Adds per-word valid bits, bubble insertion on external stall, and flush of the E stage.
- Holds multi-cycle E-stage operations (mul/div) in E for MCYC cycles while back-pressuring Decode.
- Sits between maindec/aludec outputs and the datapath stage registers; replaces fixed-width per-stage control flops.

Parameters:
W, 8, control word width in bits
STAGES, 3, number of pipeline stages after Decode (stage 0 = E, 1 = M, 2 = W, ...); legal range 2..8
MCYC, 4, E-stage occupancy in cycles for a multi-cycle word; legal range 1..16; 1 means no hold

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous active-high reset
ctrlD  in  W  control word from Decode
validD  in  1  Decode holds a real instruction
mcD  in  1  Decode word is a multi-cycle E operation
stallD  in  1  hazard unit stalling Decode; E receives a bubble
flushE  in  1  kill the word in E; E becomes a bubble
ctrl_q  out  STAGES*W  stage k word at bits [k*W +: W]
valid_q  out  STAGES  stage k valid at bit k
busyE  out  1  E holds a multi-cycle word not yet released
stall_req  out  1  Decode must hold this cycle
stall_cycles  out  16  stall counter (see Optional Feature)

Behaviour:
- Reset (async, active-high): all ctrl_q = 0, valid_q = 0, cycle counter = 0; busyE = 0, stall_req = 0, stall_cycles = 0.
- Bubble: ctrl word all-zero with valid 0.
- Stages 1..STAGES-1 shift unconditionally each cycle: stage k takes stage k-1, except stage 1 takes a bubble when E holds (see below).
- Stage 0 (E) update, priority highest first:
  1. flushE = 1: E <- bubble; counter <- 0 (aborts an in-progress multi-cycle op).
  2. busyE = 1: E holds its word; stage 1 <- bubble; counter decrements.
  3. stallD = 1: E <- bubble.
  4. Otherwise: E <- {ctrlD, validD}.
- Counter load: when E loads a word with validD = 1, mcD = 1 and MCYC > 1, the counter is loaded with MCYC-1. mcD is ignored when validD = 0.
- busyE = (counter != 0), combinational from state.
- E occupancy: a multi-cycle word occupies E for exactly MCYC cycles and enters stage 1 on the edge where the counter is 0.
- stall_req = busyE & ~flushE (combinational); Decode must present the same word next cycle.
- A single-cycle word (mcD = 0, or MCYC = 1) has latency 1 cycle per stage. The word entering E at edge n appears in stage k after edge n+k.
- stallD asserted while busyE: no effect (hold has priority); no bubble is double-counted.
- flushE and busyE on the same cycle: flush wins; stall_req = 0 that cycle.
- Reset mid multi-cycle: counter cleared immediately; no partial word released.
- Counter width: clog2(MCYC), minimum 1 bit.

Optional Feature:
Macro: CTRL_PIPE_STALL_CNT_EN.
- Defined: stall_cycles is a 16-bit counter, reset to 0. It increments on every cycle where stall_req | stallD = 1 and saturates at 16'hFFFF.
- Undefined: no counter is synthesised; stall_cycles is tied to 0.

Test Plan:
1. W=8, STAGES=3, MCYC=4. Drive ctrlD=8'hA5, validD=1 for one cycle, then validD=0. Required: valid_q[0] after edge 1, ctrl_q[15:8]=8'hA5 after edge 2, ctrl_q[23:16]=8'hA5 after edge 3; other stages are bubbles.
2. Load a word 8'h3C with mcD=1. Required: busyE=1 and stall_req=1 for 3 cycles; E holds 8'h3C for 4 cycles; stage 1 is a bubble for 3 cycles, then receives 8'h3C. The next word (8'h11) enters E on the release edge.
3. stallD=1 for 2 cycles with ctrlD=8'hFF, validD=1. Required: two bubbles (valid 0, ctrl 0) propagate through stages 0..2; 8'hFF enters E once stallD drops.
4. Start a multi-cycle word, assert flushE on its 2nd busy cycle. Required: E becomes a bubble next edge, busyE=0, stall_req=0 in the flush cycle; the word never reaches stage 1.
5. Assert reset asynchronously mid-cycle during a multi-cycle hold. Required: all outputs are 0 immediately, before the next clock edge; normal flow resumes after reset deasserts.
6. With CTRL_PIPE_STALL_CNT_EN defined, run scenario 2 then scenario 3. Required: stall_cycles = 5. Force more than 65535 stall cycles: stall_cycles stays at 16'hFFFF. Without the macro, stall_cycles stays 0.
